// File: rtl/conv_line_controller.sv
// rtl/conv_line_controller.sv - row-convolution sequencer: source reads, sliding window, buffer writes
// Build option: CONV_ZERO_PAD_EN selects zero border samples instead of reflect-101 mirroring.
module conv_line_controller #(
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 8,
  parameter int RADIUS = 5,
  parameter int RD_LAT = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [DIM_W-1:0]              nrows_i,
  input  logic [DIM_W-1:0]              ncols_i,
  input  logic                          transpose_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          src_rd_en_o,
  output logic [DIM_W-1:0]              src_row_o,
  output logic [DIM_W-1:0]              src_col_o,
  input  logic [PIX_W-1:0]              src_dout_i,
  output logic [(2*RADIUS+1)*PIX_W-1:0] win_o,
  input  logic [PIX_W-1:0]              kern_res_i,
  output logic                          buf_wr_en_o,
  output logic [DIM_W-1:0]              buf_row_o,
  output logic [DIM_W-1:0]              buf_col_o,
  output logic [PIX_W-1:0]              buf_din_o
);

  localparam int N = 2*RADIUS+1;
  localparam logic [DIM_W-1:0] RAD_D = DIM_W'(RADIUS);
  localparam logic [DIM_W-1:0] TWO_R = DIM_W'(2*RADIUS);
  localparam logic signed [DIM_W:0] RAD_S = (DIM_W+1)'(RADIUS);
  localparam logic signed [DIM_W:0] ONE_S = (DIM_W+1)'(1);
  localparam int FL_W = $clog2(RD_LAT+2) + 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(RD_LAT+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // Slot tag travelling alongside the SRAM latency so data and write info line up
  typedef struct packed {
    logic             v;
    logic             zero;
    logic             wr;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } tag_t;

  state_t state_q, state_d;
  logic [DIM_W-1:0] nrows_q, ncols_q, s_q, r_q;
  logic             transpose_q, busy_q, done_q, err_q;
  logic [FL_W-1:0]  fl_q;
  logic             rd_en_q, wr_en_q;
  logic [DIM_W-1:0] rd_row_q, rd_col_q, wr_row_q, wr_col_q;
  logic [N*PIX_W-1:0] win_q;
  tag_t             tag_q [RD_LAT+1];
  tag_t             tag_d;

  logic issue, accept, reject, finish, start_ok, row_end, last_row;
  logic [DIM_W-1:0] last_s, wcol, col_rd, c_u, nc1_u;
  logic signed [DIM_W:0] c_s, ncm1_s;
  logic c_lo, c_hi, rd_issue, zpad;
  logic [PIX_W-1:0] pix;

  assign start_ok = (ncols_i > RAD_D) && (nrows_i != '0);
  assign last_s   = ncols_q + TWO_R - 1'b1;
  assign row_end  = (s_q == last_s);
  assign last_row = (r_q == nrows_q - 1'b1);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && start_ok) state_d = S_RUN;
      S_RUN:   if (row_end && last_row) state_d = S_FLUSH;
      S_FLUSH: if (fl_q == FL_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: read slot issue, start accept/reject, frame finish
  always_comb begin
    issue  = (state_q == S_RUN);
    accept = (state_q == S_IDLE) && start_i && start_ok;
    reject = (state_q == S_IDLE) && start_i && !start_ok;
    finish = (state_q == S_FLUSH) && (fl_q == FL_LAST);
  end

  // Source column for extended index s (mirror math in DIM_W+1 signed bits) and write tag
  always_comb begin
    c_s    = $signed({1'b0, s_q}) - RAD_S;
    ncm1_s = $signed({1'b0, ncols_q}) - ONE_S;
    c_lo   = c_s[DIM_W];
    c_hi   = !c_lo && (c_s > ncm1_s);
    c_u    = c_s[DIM_W-1:0];
    nc1_u  = ncols_q - 1'b1;
    if (c_lo)      col_rd = -c_u;
    else if (c_hi) col_rd = (nc1_u << 1) - c_u;
    else           col_rd = c_u;
`ifdef CONV_ZERO_PAD_EN
    zpad     = c_lo || c_hi;
    rd_issue = issue && !zpad;
`else
    zpad     = 1'b0;
    rd_issue = issue;
`endif
    wcol       = s_q - TWO_R;
    tag_d.v    = issue;
    tag_d.zero = zpad;
    tag_d.wr   = (s_q >= TWO_R);
    tag_d.row  = transpose_q ? wcol : r_q;
    tag_d.col  = transpose_q ? r_q : wcol;
  end

  // Frame control: latch config, row/column counters, flush counter, status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nrows_q <= '0; ncols_q <= '0; transpose_q <= 1'b0;
      s_q <= '0; r_q <= '0; fl_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      err_q  <= reject;
      done_q <= finish;
      if (accept) begin
        busy_q <= 1'b1;
        nrows_q <= nrows_i; ncols_q <= ncols_i; transpose_q <= transpose_i;
        s_q <= '0; r_q <= '0;
      end else if (finish) begin
        busy_q <= 1'b0;
      end
      if (issue) begin
        if (row_end) begin
          s_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          s_q <= s_q + 1'b1;
        end
      end
      fl_q <= (state_q == S_FLUSH) ? fl_q + 1'b1 : '0;
    end
  end

  // Registered source read port and slot-tag delay line matching the SRAM latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_en_q <= 1'b0; rd_row_q <= '0; rd_col_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      rd_en_q <= rd_issue;
      if (rd_issue) begin
        rd_row_q <= r_q;
        rd_col_q <= col_rd;
      end
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Shift the arriving sample into the top tap and register the matching buffer write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q <= '0; wr_en_q <= 1'b0; wr_row_q <= '0; wr_col_q <= '0;
    end else begin
      wr_en_q <= tag_q[RD_LAT].v && tag_q[RD_LAT].wr;
      if (tag_q[RD_LAT].v) begin
        win_q    <= {pix, win_q[N*PIX_W-1:PIX_W]};
        wr_row_q <= tag_q[RD_LAT].row;
        wr_col_q <= tag_q[RD_LAT].col;
      end
    end
  end

  assign pix         = tag_q[RD_LAT].zero ? '0 : src_dout_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign src_rd_en_o = rd_en_q;
  assign src_row_o   = rd_row_q;
  assign src_col_o   = rd_col_q;
  assign win_o       = win_q;
  assign buf_wr_en_o = wr_en_q;
  assign buf_row_o   = wr_row_q;
  assign buf_col_o   = wr_col_q;
  assign buf_din_o   = kern_res_i;

endmodule

// File: tb/tb_conv_line_controller.sv
// tb/tb_conv_line_controller.sv - directed self-checking bench for conv_line_controller
module tb_conv_line_controller;

  localparam int LOGN = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [7:0]  nrows = 8'd0, ncols = 8'd0;
  logic        transpose = 1'b0;

  logic        busy1, done1, err1, rd_en1, wr_en1;
  logic [7:0]  src_row1, src_col1, buf_row1, buf_col1, buf_din1, kern1;
  logic [7:0]  dout1 = 8'd0;
  logic [87:0] win1;

  logic        busy3, done3, err3, rd_en3, wr_en3;
  logic [7:0]  src_row3, src_col3, buf_row3, buf_col3, buf_din3, kern3;
  logic [7:0]  p3 [3];
  logic [87:0] win3;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  logic [7:0]  rd_col_l1 [LOGN], rd_row_l1 [LOGN];
  int          rd_cyc_l1 [LOGN];
  int          rd_n1 = 0;
  logic [7:0]  wr_row_l1 [LOGN], wr_col_l1 [LOGN], wr_din_l1 [LOGN];
  logic [87:0] wr_win_l1 [LOGN];
  int          wr_cyc_l1 [LOGN];
  int          wr_n1 = 0;
  int          rd_cyc_l3 [LOGN];
  int          rd_n3 = 0;
  logic [7:0]  wr_din_l3 [LOGN];
  int          wr_cyc_l3 [LOGN];
  int          wr_n3 = 0;
  int          done_n1 = 0;

  conv_line_controller dut (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .nrows_i(nrows), .ncols_i(ncols),
    .transpose_i(transpose), .busy_o(busy1), .done_o(done1), .err_o(err1),
    .src_rd_en_o(rd_en1), .src_row_o(src_row1), .src_col_o(src_col1), .src_dout_i(dout1),
    .win_o(win1), .kern_res_i(kern1), .buf_wr_en_o(wr_en1), .buf_row_o(buf_row1),
    .buf_col_o(buf_col1), .buf_din_o(buf_din1)
  );

  conv_line_controller #(.RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .nrows_i(nrows), .ncols_i(ncols),
    .transpose_i(transpose), .busy_o(busy3), .done_o(done3), .err_o(err3),
    .src_rd_en_o(rd_en3), .src_row_o(src_row3), .src_col_o(src_col3), .src_dout_i(p3[2]),
    .win_o(win3), .kern_res_i(kern3), .buf_wr_en_o(wr_en3), .buf_row_o(buf_row3),
    .buf_col_o(buf_col3), .buf_din_o(buf_din3)
  );

  always #5 clk = ~clk;

  // identity kernel: centre tap
  assign kern1 = win1[5*8 +: 8];
  assign kern3 = win3[5*8 +: 8];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dout1 <= rd_en1 ? src_col1 : 8'd0;
    p3[0] <= rd_en3 ? 8'h80 : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  always @(negedge clk) begin
    if (rd_en1 && rd_n1 < LOGN) begin
      rd_col_l1[rd_n1] <= src_col1; rd_row_l1[rd_n1] <= src_row1;
      rd_cyc_l1[rd_n1] <= cyc;      rd_n1 <= rd_n1 + 1;
    end
    if (wr_en1 && wr_n1 < LOGN) begin
      wr_row_l1[wr_n1] <= buf_row1; wr_col_l1[wr_n1] <= buf_col1;
      wr_din_l1[wr_n1] <= buf_din1; wr_win_l1[wr_n1] <= win1;
      wr_cyc_l1[wr_n1] <= cyc;      wr_n1 <= wr_n1 + 1;
    end
    if (done1) done_n1 <= done_n1 + 1;
    if (rd_en3 && rd_n3 < LOGN) begin
      rd_cyc_l3[rd_n3] <= cyc; rd_n3 <= rd_n3 + 1;
    end
    if (wr_en3 && wr_n3 < LOGN) begin
      wr_din_l3[wr_n3] <= buf_din3; wr_cyc_l3[wr_n3] <= cyc; wr_n3 <= wr_n3 + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic go1(input logic [7:0] nr, input logic [7:0] nc, input logic tr, output int s0);
    tick();
    nrows = nr; ncols = nc; transpose = tr; start1 = 1'b1; s0 = cyc;
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_done1(output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 200; k++) begin
      if (done1) begin dcyc = cyc; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err1); end
    n_cmp++; if (rd_en1 !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %0b want 0", rd_en1); end
    n_cmp++; if (wr_en1 !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %0b want 0", wr_en1); end
    n_cmp++; if (win1 !== 88'd0) begin n_bad++; $display("FAIL reset_win got %h want 0", win1); end
    n_cmp++; if (src_col1 !== 8'd0) begin n_bad++; $display("FAIL reset_src_col got %0d want 0", src_col1); end
    n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL reset_busy3 got %0b want 0", busy3); end
    rst = 1'b0;
  endtask

  task automatic test_single_row();
    logic [7:0]  exp8 [18] = '{5,4,3,2,1,0,1,2,3,4,5,6,7,6,5,4,3,2};
    logic [87:0] w0 = {8'd5,8'd4,8'd3,8'd2,8'd1,8'd0,8'd1,8'd2,8'd3,8'd4,8'd5};
    logic [87:0] w2 = {8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1,8'd0,8'd1,8'd2,8'd3};
    int s0, dc, rb, wb;
    rb = rd_n1; wb = wr_n1;
    go1(8'd1, 8'd8, 1'b0, s0);
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL row_busy_set got %0b want 1", busy1); end
    repeat (5) tick();
    nrows = 8'd4; ncols = 8'd20; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(dc);
    n_cmp++; if (dc - s0 !== 22) begin n_bad++; $display("FAIL row_done_time got %0d want 22", dc - s0); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL row_busy_at_done got %0b want 0", busy1); end
    n_cmp++; if (rd_n1 - rb !== 18) begin n_bad++; $display("FAIL row_reads got %0d want 18", rd_n1 - rb); end
    for (int i = 0; i < 18; i++) begin
      n_cmp++; if (rd_col_l1[rb+i] !== exp8[i]) begin n_bad++;
        $display("FAIL row_rd_col[%0d] got %0d want %0d", i, rd_col_l1[rb+i], exp8[i]); end
      n_cmp++; if (rd_cyc_l1[rb+i] - s0 !== 2 + i) begin n_bad++;
        $display("FAIL row_rd_time[%0d] got %0d want %0d", i, rd_cyc_l1[rb+i] - s0, 2 + i); end
    end
    n_cmp++; if (wr_n1 - wb !== 8) begin n_bad++; $display("FAIL row_writes got %0d want 8", wr_n1 - wb); end
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (wr_col_l1[wb+j] !== 8'(j) || wr_row_l1[wb+j] !== 8'd0) begin n_bad++;
        $display("FAIL row_wr_addr[%0d] got %0d,%0d want 0,%0d", j, wr_row_l1[wb+j], wr_col_l1[wb+j], j); end
      n_cmp++; if (wr_din_l1[wb+j] !== 8'(j)) begin n_bad++;
        $display("FAIL row_wr_din[%0d] got %0d want %0d", j, wr_din_l1[wb+j], j); end
      n_cmp++; if (wr_cyc_l1[wb+j] - s0 !== 14 + j) begin n_bad++;
        $display("FAIL row_wr_time[%0d] got %0d want %0d", j, wr_cyc_l1[wb+j] - s0, 14 + j); end
    end
    n_cmp++; if (wr_win_l1[wb] !== w0) begin n_bad++; $display("FAIL row_win0 got %h want %h", wr_win_l1[wb], w0); end
    n_cmp++; if (wr_win_l1[wb+2] !== w2) begin n_bad++; $display("FAIL row_win2 got %h want %h", wr_win_l1[wb+2], w2); end
    tick();
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL row_done_pulse got %0b want 0", done1); end
  endtask

  task automatic test_back_to_back_transpose();
    logic [7:0] exp8 [18] = '{5,4,3,2,1,0,1,2,3,4,5,6,7,6,5,4,3,2};
    int s0, dc, rb, wb;
    rb = rd_n1; wb = wr_n1;
    go1(8'd3, 8'd8, 1'b1, s0);
    wait_done1(dc);
    n_cmp++; if (dc - s0 !== 58) begin n_bad++; $display("FAIL tr_done_time got %0d want 58", dc - s0); end
    n_cmp++; if (rd_n1 - rb !== 54) begin n_bad++; $display("FAIL tr_reads got %0d want 54", rd_n1 - rb); end
    for (int k = 0; k < 54; k++) begin
      n_cmp++; if (rd_row_l1[rb+k] !== 8'(k/18) || rd_col_l1[rb+k] !== exp8[k%18]) begin n_bad++;
        $display("FAIL tr_rd[%0d] got %0d,%0d want %0d,%0d", k, rd_row_l1[rb+k], rd_col_l1[rb+k], k/18, exp8[k%18]); end
      n_cmp++; if (rd_cyc_l1[rb+k] - s0 !== 2 + k) begin n_bad++;
        $display("FAIL tr_rd_time[%0d] got %0d want %0d", k, rd_cyc_l1[rb+k] - s0, 2 + k); end
    end
    n_cmp++; if (wr_n1 - wb !== 24) begin n_bad++; $display("FAIL tr_writes got %0d want 24", wr_n1 - wb); end
    for (int k = 0; k < 24; k++) begin
      n_cmp++; if (wr_row_l1[wb+k] !== 8'(k%8) || wr_col_l1[wb+k] !== 8'(k/8)) begin n_bad++;
        $display("FAIL tr_wr_addr[%0d] got %0d,%0d want %0d,%0d", k, wr_row_l1[wb+k], wr_col_l1[wb+k], k%8, k/8); end
      n_cmp++; if (wr_din_l1[wb+k] !== 8'(k%8)) begin n_bad++;
        $display("FAIL tr_wr_din[%0d] got %0d want %0d", k, wr_din_l1[wb+k], k%8); end
    end
  endtask

  task automatic test_err();
    int s0, dc, rb, wb;
    logic [7:0] exp6 [16] = '{5,4,3,2,1,0,1,2,3,4,5,4,3,2,1,0};
    rb = rd_n1; wb = wr_n1;
    go1(8'd1, 8'd5, 1'b0, s0);
    n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_ncols got %0b want 1", err1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL err_ncols_busy got %0b want 0", busy1); end
    tick();
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %0b want 0", err1); end
    go1(8'd0, 8'd8, 1'b0, s0);
    n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_nrows got %0b want 1", err1); end
    repeat (10) tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL err_busy_after got %0b want 0", busy1); end
    n_cmp++; if (rd_n1 !== rb || wr_n1 !== wb) begin n_bad++;
      $display("FAIL err_no_traffic got %0d reads %0d writes want 0", rd_n1 - rb, wr_n1 - wb); end
    go1(8'd1, 8'd6, 1'b0, s0);
    n_cmp++; if (err1 !== 1'b0 || busy1 !== 1'b1) begin n_bad++;
      $display("FAIL edge_ncols6_accept got err %0b busy %0b want 0,1", err1, busy1); end
    wait_done1(dc);
    n_cmp++; if (dc - s0 !== 20) begin n_bad++; $display("FAIL edge_done_time got %0d want 20", dc - s0); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rd_col_l1[rb+i] !== exp6[i]) begin n_bad++;
        $display("FAIL edge_rd_col[%0d] got %0d want %0d", i, rd_col_l1[rb+i], exp6[i]); end
    end
    n_cmp++; if (wr_n1 - wb !== 6) begin n_bad++; $display("FAIL edge_writes got %0d want 6", wr_n1 - wb); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (wr_col_l1[wb+j] !== 8'(j) || wr_din_l1[wb+j] !== 8'(j)) begin n_bad++;
        $display("FAIL edge_wr[%0d] got col %0d din %0d want %0d", j, wr_col_l1[wb+j], wr_din_l1[wb+j], j); end
    end
  endtask

  task automatic test_rdlat3();
    int s0, dc, rb, wb, ri;
    rb = rd_n3; wb = wr_n3; dc = -1;
    tick();
    nrows = 8'd2; ncols = 8'd8; transpose = 1'b0; start3 = 1'b1; s0 = cyc;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done3) begin dc = cyc; break; end
      tick();
    end
    n_cmp++; if (dc - s0 !== 42) begin n_bad++; $display("FAIL lat3_done_time got %0d want 42", dc - s0); end
    n_cmp++; if (wr_n3 - wb !== 16) begin n_bad++; $display("FAIL lat3_writes got %0d want 16", wr_n3 - wb); end
    for (int k = 0; k < 16; k++) begin
      ri = rb + (k/8)*18 + (k%8) + 10;
      n_cmp++; if (wr_din_l3[wb+k] !== 8'h80) begin n_bad++;
        $display("FAIL lat3_din[%0d] got %h want 80", k, wr_din_l3[wb+k]); end
      n_cmp++; if (wr_cyc_l3[wb+k] - rd_cyc_l3[ri] !== 4) begin n_bad++;
        $display("FAIL lat3_latency[%0d] got %0d want 4", k, wr_cyc_l3[wb+k] - rd_cyc_l3[ri]); end
    end
  endtask

  task automatic test_abort();
    int s0, dc, wb, db;
    go1(8'd2, 8'd8, 1'b0, s0);
    repeat (25) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy1); end
    n_cmp++; if (wr_en1 !== 1'b0) begin n_bad++; $display("FAIL abort_wr_en got %0b want 0", wr_en1); end
    n_cmp++; if (rd_en1 !== 1'b0) begin n_bad++; $display("FAIL abort_rd_en got %0b want 0", rd_en1); end
    wb = wr_n1; db = done_n1;
    repeat (30) tick();
    n_cmp++; if (wr_n1 !== wb || done_n1 !== db) begin n_bad++;
      $display("FAIL abort_quiet got %0d writes %0d dones want 0", wr_n1 - wb, done_n1 - db); end
    wb = wr_n1;
    go1(8'd1, 8'd8, 1'b0, s0);
    wait_done1(dc);
    n_cmp++; if (dc - s0 !== 22) begin n_bad++; $display("FAIL abort_rerun_time got %0d want 22", dc - s0); end
    n_cmp++; if (wr_n1 - wb !== 8) begin n_bad++; $display("FAIL abort_rerun_writes got %0d want 8", wr_n1 - wb); end
    n_cmp++; if (wr_din_l1[wb+7] !== 8'd7) begin n_bad++;
      $display("FAIL abort_rerun_din7 got %0d want 7", wr_din_l1[wb+7]); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back_transpose();
    test_err();
    test_rdlat3();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
